gtwizard_usrclk_activity_monitor: RTL and testbench



---
 rtl/gtwizard_usrclk_pkg.sv | 41 ++++
 rtl/gtwizard_usrclk_lane_monitor.sv | 158 +++++++++++++++
 rtl/gtwizard_usrclk_activity_monitor.sv | 104 ++++++++++
 tb/tb_gtwizard_usrclk_activity_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gtwizard_usrclk_pkg.sv
// Shared definitions for the GT user-clock activity monitor.
// Holds the per-lane FSM encoding, lane-index helpers and counter width
// derivations used by the top level and the lane monitor.
package gtwizard_usrclk_pkg;

    // Per-lane qualification FSM encoding.
    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_ACTIVE  = 2'd2
    } lane_state_e;

    // Each GT channel contributes one TX lane and one RX lane.
    localparam int unsigned LANES_PER_CHANNEL = 2;
    // TX lanes occupy the low indices, RX lanes follow.
    localparam int unsigned TX_LANE_BASE      = 0;

    // Lane index of channel ch's TX user clock.
    function automatic int unsigned tx_lane_idx(input int unsigned ch);
        return TX_LANE_BASE + ch;
    endfunction

    // Lane index of channel ch's RX user clock.
    function automatic int unsigned rx_lane_idx(input int unsigned num_ch,
                                                input int unsigned ch);
        return TX_LANE_BASE + num_ch + ch;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

    // Edge counter width: must hold a full window of edges.
    function automatic int unsigned cnt_width(input int unsigned window_cycles);
        return width_for(window_cycles);
    endfunction

endpackage : gtwizard_usrclk_pkg

// File: rtl/gtwizard_usrclk_lane_monitor.sv
// One-lane user-clock qualifier.
// Synchronises an asynchronous heartbeat toggle, counts both edges per
// measurement window, judges the window against the in-band limits and runs
// the DOWN/QUALIFY/ACTIVE FSM with a sticky fault flag.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   heartbeat_in asynchronous heartbeat toggle from the usrclk domain
//   window_end   terminal cycle of the shared window counter
//   judge_en     terminal cycle of a window that receives a verdict
//   fault_clear  clears the fault flag (a simultaneous set wins)
//   active       lane qualified (registered)
//   fault        sticky ACTIVE->DOWN flag (registered)
//   last_count   edge count of the last judged window (registered)
module gtwizard_usrclk_lane_monitor
    import gtwizard_usrclk_pkg::*;
#(
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned MIN_EDGES    = 20,
    parameter int unsigned MAX_EDGES    = 28,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             heartbeat_in,
    input  logic             window_end,
    input  logic             judge_en,
    input  logic             fault_clear,
    output logic             active,
    output logic             fault,
    output logic [CNT_W-1:0] last_count
);

    localparam int unsigned GOOD_W = width_for(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_EDGES);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  last_count_q, last_count_d;
    lane_state_e       state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              active_q, active_d;
    logic              fault_q, fault_d;

    logic              edge_c;
    logic [CNT_W-1:0]  closing_cnt_c;
    logic              good_win_c;
    logic [GOOD_W-1:0] good_inc_c;
    logic              fault_set_c;

    // Synchroniser, edge detect and saturating edge counter.
    always_comb begin
        sync1_d = heartbeat_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_c  = sync2_q ^ prev_q;

        // An edge on the terminal cycle still belongs to the closing window.
        closing_cnt_c = edge_cnt_q;
        if (edge_c && !(&edge_cnt_q)) begin
            closing_cnt_c = edge_cnt_q + CNT_W'(1);
        end

        edge_cnt_d = window_end ? '0 : closing_cnt_c;
        good_win_c = (closing_cnt_c >= MIN_L) && (closing_cnt_c <= MAX_L);
        last_count_d = judge_en ? closing_cnt_c : last_count_q;
    end

    // Qualification FSM next state, good-window counter and fault flag.
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        fault_set_c = 1'b0;
        good_inc_c  = good_q + GOOD_W'(1);

        if (judge_en) begin
            unique case (state_q)
                ST_DOWN: begin
                    if (good_win_c) begin
                        if (LOCK_WINDOWS <= 1) begin
                            state_d = ST_ACTIVE;
                            good_d  = '0;
                        end else begin
                            state_d = ST_QUALIFY;
                            good_d  = GOOD_W'(1);
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (!good_win_c) begin
                        state_d = ST_DOWN;
                        good_d  = '0;
                    end else if (32'(good_inc_c) >= LOCK_WINDOWS) begin
                        state_d = ST_ACTIVE;
                        good_d  = '0;
                    end else begin
                        good_d  = good_inc_c;
                    end
                end
                ST_ACTIVE: begin
                    if (!good_win_c) begin
                        state_d     = ST_DOWN;
                        good_d      = '0;
                        fault_set_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_DOWN;
                    good_d  = '0;
                end
            endcase
        end

        active_d = (state_d == ST_ACTIVE);

        // A set on the same cycle as a clear wins.
        if (fault_set_c) begin
            fault_d = 1'b1;
        end else if (fault_clear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            edge_cnt_q   <= '0;
            last_count_q <= '0;
            state_q      <= ST_DOWN;
            good_q       <= '0;
            active_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            edge_cnt_q   <= edge_cnt_d;
            last_count_q <= last_count_d;
            state_q      <= state_d;
            good_q       <= good_d;
            active_q     <= active_d;
            fault_q      <= fault_d;
        end
    end

    assign active     = active_q;
    assign fault      = fault_q;
    assign last_count = last_count_q;

endmodule : gtwizard_usrclk_lane_monitor

// File: rtl/gtwizard_usrclk_activity_monitor.sv
// Multi-channel GT user-clock activity monitor.
// Qualifies every TX and RX user clock as running and in-band by counting
// synchronised heartbeat edges over a shared SYSCLK_IN window.
// Ports:
//   SYSCLK_IN            free-running system clock
//   SOFT_RESET_IN        synchronous active-high reset
//   GT_TXHEARTBEAT_IN    per-channel TX heartbeat toggles (asynchronous)
//   GT_RXHEARTBEAT_IN    per-channel RX heartbeat toggles (asynchronous)
//   FAULT_CLEAR_IN       pulse clearing all fault bits
//   TXUSRCLK_ACTIVE_OUT  per-channel TX clock qualified
//   RXUSRCLK_ACTIVE_OUT  per-channel RX clock qualified
//   ALL_ACTIVE_OUT       every lane qualified, one cycle behind the lanes
//   FAULT_OUT            sticky per-lane dropout flags
//   LAST_COUNT_OUT       per-lane edge count of last judged window, lane 0 low
module gtwizard_usrclk_activity_monitor
    import gtwizard_usrclk_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned MIN_EDGES     = 20,
    parameter int unsigned MAX_EDGES     = 28,
    parameter int unsigned LOCK_WINDOWS  = 4,
    localparam int unsigned CNT_W        = cnt_width(WINDOW_CYCLES)
) (
    input  logic                                  SYSCLK_IN,
    input  logic                                  SOFT_RESET_IN,
    input  logic [NUM_CHANNELS-1:0]               GT_TXHEARTBEAT_IN,
    input  logic [NUM_CHANNELS-1:0]               GT_RXHEARTBEAT_IN,
    input  logic                                  FAULT_CLEAR_IN,
    output logic [NUM_CHANNELS-1:0]               TXUSRCLK_ACTIVE_OUT,
    output logic [NUM_CHANNELS-1:0]               RXUSRCLK_ACTIVE_OUT,
    output logic                                  ALL_ACTIVE_OUT,
    output logic [LANES_PER_CHANNEL*NUM_CHANNELS-1:0]       FAULT_OUT,
    output logic [LANES_PER_CHANNEL*NUM_CHANNELS*CNT_W-1:0] LAST_COUNT_OUT
);

    localparam int unsigned NUM_LANES = LANES_PER_CHANNEL * NUM_CHANNELS;
    localparam int unsigned WIN_W     = width_for(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic                 discard_q, discard_d;
    logic                 all_active_q, all_active_d;
    logic                 term_c;
    logic                 judge_c;

    logic [NUM_LANES-1:0] lane_hb;
    logic [NUM_LANES-1:0] lane_active;
    logic [NUM_LANES-1:0] lane_fault;

    // Shared window counter and first-window discard flag.
    always_comb begin
        term_c    = (win_cnt_q == WIN_LAST);
        win_cnt_d = term_c ? '0 : win_cnt_q + WIN_W'(1);
        // Synchroniser contents are untrusted until one full window has passed.
        discard_d = term_c ? 1'b0 : discard_q;
        judge_c   = term_c && !discard_q;
        all_active_d = &lane_active;
    end

    always_ff @(posedge SYSCLK_IN) begin
        if (SOFT_RESET_IN) begin
            win_cnt_q    <= '0;
            discard_q    <= 1'b1;
            all_active_q <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            discard_q    <= discard_d;
            all_active_q <= all_active_d;
        end
    end

    // Map channel heartbeats onto lanes and lane flags back onto channels.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        assign lane_hb[tx_lane_idx(ch)]               = GT_TXHEARTBEAT_IN[ch];
        assign lane_hb[rx_lane_idx(NUM_CHANNELS, ch)] = GT_RXHEARTBEAT_IN[ch];
        assign TXUSRCLK_ACTIVE_OUT[ch] = lane_active[tx_lane_idx(ch)];
        assign RXUSRCLK_ACTIVE_OUT[ch] = lane_active[rx_lane_idx(NUM_CHANNELS, ch)];
    end

    // One monitor per lane.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        gtwizard_usrclk_lane_monitor #(
            .CNT_W        (CNT_W),
            .MIN_EDGES    (MIN_EDGES),
            .MAX_EDGES    (MAX_EDGES),
            .LOCK_WINDOWS (LOCK_WINDOWS)
        ) u_lane (
            .clk          (SYSCLK_IN),
            .rst          (SOFT_RESET_IN),
            .heartbeat_in (lane_hb[l]),
            .window_end   (term_c),
            .judge_en     (judge_c),
            .fault_clear  (FAULT_CLEAR_IN),
            .active       (lane_active[l]),
            .fault        (lane_fault[l]),
            .last_count   (LAST_COUNT_OUT[l*CNT_W +: CNT_W])
        );
    end

    assign FAULT_OUT      = lane_fault;
    assign ALL_ACTIVE_OUT = all_active_q;

endmodule : gtwizard_usrclk_activity_monitor

// File: tb/tb_gtwizard_usrclk_activity_monitor.sv
// Directed bench for the GT user-clock activity monitor (2 channels, 4 lanes).
module tb_gtwizard_usrclk_activity_monitor;

    localparam int unsigned NC = 2;
    localparam int unsigned NL = 4;
    localparam int unsigned W  = 1024;
    localparam int unsigned CW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [NC-1:0]   tx_hb, rx_hb;
    logic [NC-1:0]   tx_act, rx_act;
    logic            all_act;
    logic [NL-1:0]   fault;
    logic [NL*CW-1:0] last_cnt;

    int   hb_per [NL];
    int   hb_cnt [NL];
    logic hb_val [NL];

    int total;
    int bad;
    int cyc;

    always #5 clk = ~clk;

    gtwizard_usrclk_activity_monitor #(
        .NUM_CHANNELS  (NC),
        .WINDOW_CYCLES (W),
        .MIN_EDGES     (20),
        .MAX_EDGES     (28),
        .LOCK_WINDOWS  (4)
    ) dut (
        .SYSCLK_IN           (clk),
        .SOFT_RESET_IN       (rst),
        .GT_TXHEARTBEAT_IN   (tx_hb),
        .GT_RXHEARTBEAT_IN   (rx_hb),
        .FAULT_CLEAR_IN      (clr),
        .TXUSRCLK_ACTIVE_OUT (tx_act),
        .RXUSRCLK_ACTIVE_OUT (rx_act),
        .ALL_ACTIVE_OUT      (all_act),
        .FAULT_OUT           (fault),
        .LAST_COUNT_OUT      (last_cnt)
    );

    // Heartbeat generators: lane l toggles every hb_per[l] cycles, 0 = stopped.
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (hb_per[l] == 0) begin
                hb_cnt[l] = 0;
            end else if (hb_cnt[l] >= hb_per[l] - 1) begin
                hb_val[l] = ~hb_val[l];
                hb_cnt[l] = 0;
            end else begin
                hb_cnt[l] = hb_cnt[l] + 1;
            end
        end
    end

    assign tx_hb = {hb_val[1], hb_val[0]};
    assign rx_hb = {hb_val[3], hb_val[2]};

    function automatic logic [CW-1:0] lc(input int l);
        return last_cnt[l*CW +: CW];
    endfunction

    // cyc = 1 just after the last edge that samples reset high.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic release_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic set_all(input int p);
        for (int l = 0; l < NL; l++) hb_per[l] = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        set_all(40);
        repeat (3) step();
        total++; if ({rx_act, tx_act} !== 4'b0000) begin bad++; $display("FAIL reset_active: got %b want 0000", {rx_act, tx_act}); end
        total++; if (all_act !== 1'b0) begin bad++; $display("FAIL reset_all_active: got %b want 0", all_act); end
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL reset_fault: got %b want 0000", fault); end
        total++; if (last_cnt !== '0) begin bad++; $display("FAIL reset_last_count: got %h want 0", last_cnt); end
    endtask

    task automatic test_lock();
        release_rst();
        step_to(W + 1);
        total++; if (last_cnt !== '0) begin bad++; $display("FAIL lock_discard_first: got %h want 0", last_cnt); end
        step_to(2*W + 1);
        total++; if ($isunknown(lc(0)) || lc(0) < 25 || lc(0) > 26) begin bad++; $display("FAIL lock_count_w2: got %0d want 25..26", lc(0)); end
        total++; if ({rx_act, tx_act} !== 4'b0000) begin bad++; $display("FAIL lock_qualify_w2: got %b want 0000", {rx_act, tx_act}); end
        step_to(5*W);
        total++; if ({rx_act, tx_act} !== 4'b0000) begin bad++; $display("FAIL lock_early: got %b want 0000", {rx_act, tx_act}); end
        step();
        total++; if ({rx_act, tx_act} !== 4'b1111) begin bad++; $display("FAIL lock_active: got %b want 1111", {rx_act, tx_act}); end
        total++; if (all_act !== 1'b0) begin bad++; $display("FAIL lock_all_lag: got %b want 0", all_act); end
        step();
        total++; if (all_act !== 1'b1) begin bad++; $display("FAIL lock_all_active: got %b want 1", all_act); end
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL lock_fault: got %b want 0000", fault); end
        for (int l = 0; l < NL; l++) begin
            total++;
            if ($isunknown(lc(l)) || lc(l) < 25 || lc(l) > 26) begin
                bad++; $display("FAIL lock_count_lane%0d: got %0d want 25..26", l, lc(l));
            end
        end
    endtask

    task automatic test_fault_stop();
        int n;
        hb_per[0] = 0;
        n = 0;
        while (tx_act[0] === 1'b1 && n < 1025) begin step(); n++; end
        total++; if (tx_act[0] !== 1'b0) begin bad++; $display("FAIL stop_tx0_drop: got %b want 0 within 1025", tx_act[0]); end
        total++; if (fault !== 4'b0001) begin bad++; $display("FAIL stop_fault_set: got %b want 0001", fault); end
        total++; if (all_act !== 1'b1) begin bad++; $display("FAIL stop_all_lag: got %b want 1", all_act); end
        step();
        total++; if (all_act !== 1'b0) begin bad++; $display("FAIL stop_all_drop: got %b want 0", all_act); end
        hb_per[0] = 40;
        n = 0;
        while (tx_act[0] !== 1'b1 && n < 7*W) begin step(); n++; end
        total++; if (tx_act[0] !== 1'b1) begin bad++; $display("FAIL stop_tx0_relock: got %b want 1", tx_act[0]); end
        total++; if (fault !== 4'b0001) begin bad++; $display("FAIL stop_fault_sticky: got %b want 0001", fault); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL stop_fault_clear: got %b want 0000", fault); end
    endtask

    task automatic test_clear_collision();
        int n;
        n = 0;
        while (cyc % W != 1 && n < W) begin step(); n++; end
        total++; if (tx_act[1] !== 1'b1) begin bad++; $display("FAIL coll_pre_tx1: got %b want 1", tx_act[1]); end
        hb_per[1] = 0;
        step_to(cyc + W - 1);
        // Clear is presented on the terminal cycle of TX1's empty window.
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (tx_act[1] !== 1'b0) begin bad++; $display("FAIL coll_tx1_drop: got %b want 0", tx_act[1]); end
        total++; if (fault !== 4'b0010) begin bad++; $display("FAIL coll_set_wins: got %b want 0010", fault); end
        hb_per[1] = 40;
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        while (all_act !== 1'b1 && n < 8*W) begin step(); n++; end
        total++; if (all_act !== 1'b1) begin bad++; $display("FAIL mrst_pre_all: got %b want 1", all_act); end
        while (cyc % W != 500) step();
        rst = 1'b1;
        step();
        total++; if ({rx_act, tx_act} !== 4'b0000) begin bad++; $display("FAIL mrst_active: got %b want 0000", {rx_act, tx_act}); end
        total++; if (all_act !== 1'b0) begin bad++; $display("FAIL mrst_all: got %b want 0", all_act); end
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL mrst_fault: got %b want 0000", fault); end
        total++; if (last_cnt !== '0) begin bad++; $display("FAIL mrst_last_count: got %h want 0", last_cnt); end
        release_rst();
        step_to(5*W);
        total++; if ({rx_act, tx_act} !== 4'b0000) begin bad++; $display("FAIL mrst_early: got %b want 0000", {rx_act, tx_act}); end
        step();
        total++; if ({rx_act, tx_act} !== 4'b1111) begin bad++; $display("FAIL mrst_relock: got %b want 1111", {rx_act, tx_act}); end
        step();
        total++; if (all_act !== 1'b1) begin bad++; $display("FAIL mrst_all_relock: got %b want 1", all_act); end
    endtask

    task automatic test_qualify_bad();
        set_all(40);
        release_rst();
        step_to(4*W + 1);
        total++; if (tx_act !== 2'b00) begin bad++; $display("FAIL qual_three_good: got %b want 00", tx_act); end
        hb_per[0] = 0;
        step_to(5*W + 1);
        total++; if (tx_act !== 2'b10) begin bad++; $display("FAIL qual_bad_tx: got %b want 10", tx_act); end
        total++; if (rx_act !== 2'b11) begin bad++; $display("FAIL qual_bad_rx: got %b want 11", rx_act); end
        total++; if ($isunknown(lc(0)) || lc(0) > 1) begin bad++; $display("FAIL qual_bad_count: got %0d want 0..1", lc(0)); end
        hb_per[0] = 40;
        step_to(9*W);
        total++; if (tx_act[0] !== 1'b0) begin bad++; $display("FAIL qual_early: got %b want 0", tx_act[0]); end
        step();
        total++; if (tx_act[0] !== 1'b1) begin bad++; $display("FAIL qual_relock: got %b want 1", tx_act[0]); end
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL qual_fault: got %b want 0000", fault); end
    endtask

    task automatic test_overspeed();
        set_all(40);
        hb_per[3] = 20;
        release_rst();
        step_to(5*W + 1);
        total++; if (tx_act !== 2'b11) begin bad++; $display("FAIL ovs_tx: got %b want 11", tx_act); end
        total++; if (rx_act !== 2'b01) begin bad++; $display("FAIL ovs_rx: got %b want 01", rx_act); end
        total++; if ($isunknown(lc(3)) || lc(3) < 51 || lc(3) > 52) begin bad++; $display("FAIL ovs_count_rx1: got %0d want 51..52", lc(3)); end
        total++; if ($isunknown(lc(2)) || lc(2) < 25 || lc(2) > 26) begin bad++; $display("FAIL ovs_count_rx0: got %0d want 25..26", lc(2)); end
        step();
        total++; if (all_act !== 1'b0) begin bad++; $display("FAIL ovs_all: got %b want 0", all_act); end
        total++; if (fault !== 4'b0000) begin bad++; $display("FAIL ovs_fault: got %b want 0000", fault); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        clr   = 1'b0;
        for (int l = 0; l < NL; l++) begin
            hb_per[l] = 0;
            hb_cnt[l] = 0;
            hb_val[l] = 1'b0;
        end
        test_reset();
        test_lock();
        test_fault_stop();
        test_clear_collision();
        test_mid_reset();
        test_qualify_bad();
        test_overspeed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_gtwizard_usrclk_activity_monitor
